// File: rtl/msrh_rnid_freelist_mp_pkg.sv
// Shared types and default sizing for the multi-port rename free list.
// Default build: 2-wide dispatch, 64 entries, 7-bit RNIDs.
package msrh_rnid_freelist_mp_pkg;

    localparam int DISP_SIZE      = 2;
    localparam int FLIST_SIZE     = 32;
    localparam int RNID_W         = 7;
    localparam int SNAP_NUM       = 4;
    localparam int FREELIST_DEPTH = FLIST_SIZE * DISP_SIZE;
    localparam int FREELIST_PTR_W = $clog2(FREELIST_DEPTH) + 1;

    typedef logic [RNID_W-1:0]         rnid_t;
    typedef logic [FREELIST_PTR_W-1:0] freelist_ptr_t;

endpackage

// File: rtl/msrh_rnid_freelist_mp_if.sv
// Rename-side interface of the free list: group allocation, commit release, checkpoint control.
// The master drives requests; the slave (free list) returns ready and the allocated RNIDs.
interface msrh_rnid_freelist_mp_if
    import msrh_rnid_freelist_mp_pkg::*;
#(
    parameter int P_DISP_SIZE = DISP_SIZE,
    parameter int P_RNID_W    = RNID_W,
    parameter int P_SNAP_NUM  = SNAP_NUM
);
    logic                                  i_alloc_req;
    logic [P_DISP_SIZE-1:0]                i_alloc_mask;
    logic                                  o_alloc_ready;
    logic [P_DISP_SIZE-1:0][P_RNID_W-1:0]  o_alloc_rnid;
    logic [P_DISP_SIZE-1:0]                i_rel_valid;
    logic [P_DISP_SIZE-1:0][P_RNID_W-1:0]  i_rel_rnid;
    logic                                  i_snap_valid;
    logic [$clog2(P_SNAP_NUM)-1:0]         i_snap_id;
    logic                                  i_restore_valid;

    modport master (
        output i_alloc_req, i_alloc_mask, i_rel_valid, i_rel_rnid,
               i_snap_valid, i_snap_id, i_restore_valid,
        input  o_alloc_ready, o_alloc_rnid
    );

    modport slave (
        input  i_alloc_req, i_alloc_mask, i_rel_valid, i_rel_rnid,
               i_snap_valid, i_snap_id, i_restore_valid,
        output o_alloc_ready, o_alloc_rnid
    );

endinterface

// File: rtl/msrh_prefix_popcnt.sv
// Exclusive prefix popcount: o_prefix[k] counts set bits of i_vec[k-1:0]; o_total counts all.
module msrh_prefix_popcnt #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]         i_vec,
    output logic [N-1:0][CW-1:0] o_prefix,
    output logic [CW-1:0]        o_total
);

    always_comb begin
        logic [CW-1:0] w_acc;
        // NOTE: blocking '=' here builds a ripple chain inside one evaluation; '<=' would not.
        w_acc = '0;
        for (int k = 0; k < N; k++) begin
            o_prefix[k] = w_acc;
            w_acc       = w_acc + CW'(i_vec[k]);
        end
        o_total = w_acc;
    end

endmodule

// File: rtl/msrh_rnid_freelist_mp.sv
// Multi-port rename free list: circular FIFO of free RNIDs with group-atomic allocation.
// Head checkpoint/restore is built only when MSRH_FREELIST_SNAPSHOT_EN is defined.
module msrh_rnid_freelist_mp
    import msrh_rnid_freelist_mp_pkg::*;
#(
    parameter int DISP_SIZE = msrh_rnid_freelist_mp_pkg::DISP_SIZE,
    parameter int DEPTH     = msrh_rnid_freelist_mp_pkg::FREELIST_DEPTH,
    parameter int RNID_W    = msrh_rnid_freelist_mp_pkg::RNID_W,
    parameter int INIT_BASE = 32,
    parameter int SNAP_NUM  = msrh_rnid_freelist_mp_pkg::SNAP_NUM
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    msrh_rnid_freelist_mp_if.slave     fl_if,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty,
    output logic                       o_overflow
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(DISP_SIZE + 1);

    logic [RNID_W-1:0]             r_entry [DEPTH];
    logic [PW-1:0]                 r_head, r_tail;
    logic                          r_overflow;
    logic [PW-1:0]                 w_count, w_head_alloc, w_head_next;
    logic                          w_restore, w_ready, w_fire, w_rel_ok;
    logic [DISP_SIZE-1:0][CW-1:0]  w_alloc_pre, w_rel_pre;
    logic [CW-1:0]                 w_nalloc, w_nrel;
    logic [IW-1:0]                 w_rd_idx [DISP_SIZE];
    logic [IW-1:0]                 w_wr_idx [DISP_SIZE];

    msrh_prefix_popcnt #(.N(DISP_SIZE), .CW(CW)) u_alloc_pc (
        .i_vec(fl_if.i_alloc_mask), .o_prefix(w_alloc_pre), .o_total(w_nalloc));
    msrh_prefix_popcnt #(.N(DISP_SIZE), .CW(CW)) u_rel_pc (
        .i_vec(fl_if.i_rel_valid), .o_prefix(w_rel_pre), .o_total(w_nrel));

    assign w_count    = r_tail - r_head;
    assign o_count    = w_count;
    assign o_empty    = (w_count == '0);
    assign o_overflow = r_overflow;

    // Readiness looks only at the registered count, so same-cycle releases never help.
    assign w_ready             = (w_count >= PW'(DISP_SIZE)) && !w_restore;
    assign w_fire              = fl_if.i_alloc_req && w_ready;
    assign fl_if.o_alloc_ready = w_ready;

    assign w_head_alloc = r_head + (w_fire ? PW'(w_nalloc) : PW'(0));
    assign w_rel_ok     = ({1'b0, w_count} + (PW + 1)'(w_nrel)) <= (PW + 1)'(DEPTH);

    always_comb begin
        for (int k = 0; k < DISP_SIZE; k++) begin
            w_rd_idx[k]           = r_head[IW-1:0] + IW'(w_alloc_pre[k]);
            w_wr_idx[k]           = r_tail[IW-1:0] + IW'(w_rel_pre[k]);
            fl_if.o_alloc_rnid[k] = r_entry[w_rd_idx[k]];
        end
    end

`ifdef MSRH_FREELIST_SNAPSHOT_EN
    logic [PW-1:0] r_snap [SNAP_NUM];

    assign w_restore   = fl_if.i_restore_valid;
    assign w_head_next = w_restore ? r_snap[fl_if.i_snap_id] : w_head_alloc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s < SNAP_NUM; s++) r_snap[s] <= '0;
        end else if (fl_if.i_snap_valid && !w_restore) begin
            r_snap[fl_if.i_snap_id] <= w_head_alloc;
        end
    end
`else
    logic w_unused_snap;

    assign w_restore     = 1'b0;
    assign w_head_next   = w_head_alloc;
    assign w_unused_snap = ^{fl_if.i_snap_valid, fl_if.i_snap_id, fl_if.i_restore_valid};
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            // NOTE: the entry array is reset on purpose -- its contents are the initial free RNIDs.
            for (int i = 0; i < DEPTH; i++) r_entry[i] <= RNID_W'(INIT_BASE + i);
            r_head     <= '0;
            r_tail     <= PW'(DEPTH);
            r_overflow <= 1'b0;
        end else begin
            r_head <= w_head_next;
            if (w_rel_ok) begin
                for (int k = 0; k < DISP_SIZE; k++) begin
                    if (fl_if.i_rel_valid[k]) r_entry[w_wr_idx[k]] <= fl_if.i_rel_rnid[k];
                end
                r_tail <= r_tail + PW'(w_nrel);
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_msrh_rnid_freelist_mp.sv
// Directed self-checking bench for msrh_rnid_freelist_mp with a FIFO scoreboard of free RNIDs.
// Checkpoint expectations follow MSRH_FREELIST_SNAPSHOT_EN.
module tb_msrh_rnid_freelist_mp;
    import msrh_rnid_freelist_mp_pkg::*;

    localparam int D = FREELIST_DEPTH;

    logic                      clk = 1'b0;
    logic                      i_reset;
    logic [FREELIST_PTR_W-1:0] o_count;
    logic                      o_empty, o_overflow;

    always #5 clk = ~clk;

    msrh_rnid_freelist_mp_if fl_if ();

    msrh_rnid_freelist_mp dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .fl_if     (fl_if),
        .o_count   (o_count),
        .o_empty   (o_empty),
        .o_overflow(o_overflow)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    rnid_t model_q[$];
    rnid_t held_q[$];
    bit    exp_ovf;
    logic  cap_ready;
    rnid_t cap_rnid[2];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive_idle();
        fl_if.i_alloc_req     = 1'b0;
        fl_if.i_alloc_mask    = '0;
        fl_if.i_rel_valid     = '0;
        fl_if.i_rel_rnid      = '0;
        fl_if.i_snap_valid    = 1'b0;
        fl_if.i_snap_id       = '0;
        fl_if.i_restore_valid = 1'b0;
    endtask

    // Drive at negedge, capture combinational outputs, then let one posedge commit.
    task automatic step(input logic req, input logic [1:0] mask, input logic [1:0] rv,
                        input rnid_t r0, input rnid_t r1, input logic sv,
                        input logic [1:0] sid, input logic rs);
        @(negedge clk);
        fl_if.i_alloc_req     = req;
        fl_if.i_alloc_mask    = mask;
        fl_if.i_rel_valid     = rv;
        fl_if.i_rel_rnid[0]   = r0;
        fl_if.i_rel_rnid[1]   = r1;
        fl_if.i_snap_valid    = sv;
        fl_if.i_snap_id       = sid;
        fl_if.i_restore_valid = rs;
        #1;
        cap_ready   = fl_if.o_alloc_ready;
        cap_rnid[0] = fl_if.o_alloc_rnid[0];
        cap_rnid[1] = fl_if.o_alloc_rnid[1];
        @(posedge clk);
        #1;
        drive_idle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        model_q.delete();
        held_q.delete();
        for (int i = 0; i < D; i++) model_q.push_back(rnid_t'(32 + i));
        exp_ovf = 1'b0;
    endtask

    // One cycle checked against the scoreboard; releases are drawn from held RNIDs in order.
    task automatic txn(input logic req, input logic [1:0] mask, input logic [1:0] rv,
                       input string tag);
        rnid_t r0 = '0;
        rnid_t r1 = '0;
        int    size_before;
        bit    exp_ready, fire, drop;
        if (rv[0]) r0 = held_q.pop_front();
        if (rv[1]) r1 = held_q.pop_front();
        size_before = model_q.size();
        exp_ready   = (size_before >= 2);
        fire        = req && exp_ready;
        drop        = (size_before + int'(rv[0]) + int'(rv[1])) > D;
        step(req, mask, rv, r0, r1, 1'b0, 2'd0, 1'b0);
        check({tag, "_ready"}, cap_ready, exp_ready);
        if (fire) begin
            if (mask[0]) begin
                check({tag, "_slot0"}, cap_rnid[0], model_q[0]);
                held_q.push_back(model_q.pop_front());
            end
            if (mask[1]) begin
                check({tag, "_slot1"}, cap_rnid[1], model_q[0]);
                held_q.push_back(model_q.pop_front());
            end
        end
        if (drop) exp_ovf = 1'b1;
        else begin
            if (rv[0]) model_q.push_back(r0);
            if (rv[1]) model_q.push_back(r1);
        end
        check({tag, "_count"}, o_count, model_q.size());
        check({tag, "_empty"}, o_empty, model_q.size() == 0);
        check({tag, "_ovf"}, o_overflow, exp_ovf);
    endtask

    initial begin
        i_reset = 1'b1;
        drive_idle();
        do_reset();

        check("rst_count", o_count, 64);
        check("rst_empty", o_empty, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_ready", fl_if.o_alloc_ready, 1);

        // Basic allocation order.
        txn(1'b1, 2'b11, 2'b00, "t1a");
        check("t1_rnid0", cap_rnid[0], 32);
        check("t1_rnid1", cap_rnid[1], 33);
        txn(1'b1, 2'b10, 2'b00, "t1b");
        check("t1_slot1_34", cap_rnid[1], 34);
        check("t1_count61", o_count, 61);

        // Drain to one entry, then a blocked group.
        txn(1'b1, 2'b01, 2'b00, "t2_odd");
        repeat (29) txn(1'b1, 2'b11, 2'b00, "t2_drain");
        txn(1'b1, 2'b01, 2'b00, "t2_last");
        check("t2_count1", o_count, 1);
        txn(1'b1, 2'b01, 2'b00, "t2_blocked");
        check("t2_not_ready", cap_ready, 0);
        check("t2_count_hold", o_count, 1);
        txn(1'b0, 2'b00, 2'b01, "t2_rel");
        check("t2_ready_again", fl_if.o_alloc_ready, 1);
        txn(1'b1, 2'b01, 2'b00, "t2_head_kept");
        check("t2_rnid95", cap_rnid[0], 95);

        // Same-cycle alloc and release at count 10.
        repeat (4) txn(1'b0, 2'b00, 2'b11, "t3_fill");
        txn(1'b0, 2'b00, 2'b01, "t3_fill1");
        check("t3_count10", o_count, 10);
        txn(1'b1, 2'b11, 2'b11, "t3_both");
        check("t3_count_stays", o_count, 10);

        // Wrap-around streaming.
        repeat (40) txn(1'b1, 2'b11, 2'b11, "t4_wrap");
        check("t4_count10", o_count, 10);

        // Fill completely, then release into a full list.
        while (held_q.size() >= 2) txn(1'b0, 2'b00, 2'b11, "t5_fill");
        if (held_q.size() == 1) txn(1'b0, 2'b00, 2'b01, "t5_fill1");
        check("t5_full", o_count, 64);
        step(1'b0, 2'b00, 2'b01, rnid_t'(5), rnid_t'(0), 1'b0, 2'd0, 1'b0);
        exp_ovf = 1'b1;
        check("t5_ovf_set", o_overflow, 1);
        check("t5_count_hold", o_count, 64);
        step(1'b0, 2'b00, 2'b00, '0, '0, 1'b0, 2'd0, 1'b0);
        check("t5_ovf_sticky", o_overflow, 1);
        txn(1'b1, 2'b11, 2'b00, "t5_after");
        do_reset();
        check("t5_ovf_cleared", o_overflow, 0);
        check("t5_count_reset", o_count, 64);

        // Checkpoint: snapshot taken together with an allocation stores the post-alloc head.
        repeat (4) txn(1'b1, 2'b11, 2'b00, "t6_pre");
        step(1'b1, 2'b11, 2'b00, '0, '0, 1'b1, 2'd1, 1'b0);
        check("t6_snap_rnid0", cap_rnid[0], 40);
        check("t6_snap_rnid1", cap_rnid[1], 41);
        check("t6_count54", o_count, 54);
        repeat (3) step(1'b1, 2'b11, 2'b00, '0, '0, 1'b0, 2'd0, 1'b0);
        check("t6_count48", o_count, 48);
        step(1'b1, 2'b11, 2'b00, '0, '0, 1'b0, 2'd1, 1'b1);
`ifdef MSRH_FREELIST_SNAPSHOT_EN
        check("t6_restore_ready", cap_ready, 0);
        check("t6_restore_count", o_count, 54);
        step(1'b1, 2'b11, 2'b00, '0, '0, 1'b0, 2'd0, 1'b0);
        check("t6_reissue0", cap_rnid[0], 42);
        check("t6_reissue1", cap_rnid[1], 43);
`else
        check("t6_ignored_ready", cap_ready, 1);
        check("t6_ignored_count", o_count, 46);
        step(1'b1, 2'b11, 2'b00, '0, '0, 1'b0, 2'd0, 1'b0);
        check("t6_next0", cap_rnid[0], 50);
        check("t6_next1", cap_rnid[1], 51);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
